// File: rtl/spi_cmd_pkg.sv
// Shared command definitions for the SPI command path: opcode constants,
// decoder state encoding and the opcode -> payload length lookup.
package spi_cmd_pkg;

  localparam int unsigned MAX_PAYLOAD = 4;
  localparam int unsigned LEN_W       = $clog2(MAX_PAYLOAD + 1);

  localparam logic [7:0] OP_NOP         = 8'h00;
  localparam logic [7:0] OP_INPUT_FIRE  = 8'h01;
  localparam logic [7:0] OP_STEP        = 8'h02;
  localparam logic [7:0] OP_CFG_WRITE   = 8'h04;
  localparam logic [7:0] OP_CLEAR       = 8'h08;
  localparam logic [7:0] OP_READ_METRIC = 8'h10;

  typedef enum logic [1:0] {
    IDLE    = 2'd0,
    PAYLOAD = 2'd1,
    EMIT    = 2'd2
  } cmd_state_t;

  typedef struct packed {
    logic             valid;
    logic [LEN_W-1:0] len;
  } op_info_t;

  // Payload length for an opcode; valid=0 marks an unknown opcode.
  function automatic op_info_t op_len(input logic [7:0] op);
    op_info_t info;
    info.valid = 1'b1;
    info.len   = '0;
    case (op)
      OP_NOP:         info.len = LEN_W'(0);
      OP_INPUT_FIRE:  info.len = LEN_W'(2);
      OP_STEP:        info.len = LEN_W'(1);
      OP_CFG_WRITE:   info.len = LEN_W'(4);
      OP_CLEAR:       info.len = LEN_W'(0);
      OP_READ_METRIC: info.len = LEN_W'(1);
      default:        info.valid = 1'b0;
    endcase
    return info;
  endfunction

endpackage

// File: rtl/spi_cmd_decoder_sat_counter.sv
// Saturating up-counter with synchronous active-high clear.
// Ports: clk, reset (sync, active-high), inc (count one event), count (registered value).
module spi_cmd_decoder_sat_counter #(
  parameter int unsigned W = 8
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         inc,
  output logic [W-1:0] count
);

  // Hold at all-ones instead of wrapping.
  always_ff @(posedge clk) begin
    if (reset) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/spi_cmd_decoder.sv
// Frames the SPI slave's received byte stream into opcode + payload commands
// and hands one complete command per cmd_vld/cmd_rdy handshake to core control.
// Unknown opcodes are dropped and counted in err_count (saturating at 255).
// Optional: define SPI_CMD_TIMEOUT_EN to abort partial packets after
// TIMEOUT_CYCLES cycles in PAYLOAD without an accepted byte.
// Ports:
//   clk, reset           - core clock, synchronous active-high reset
//   in_data/in_vld/in_rdy - byte stream from the SPI slave
//   cmd_op/cmd_len/cmd_payload/cmd_vld/cmd_rdy - command output handshake
//   busy                 - a packet is partially assembled
//   err_count            - discarded opcodes plus aborted packets
module spi_cmd_decoder #(
  parameter int unsigned WIDTH          = 8,
  parameter int unsigned MAX_PAYLOAD    = spi_cmd_pkg::MAX_PAYLOAD
`ifdef SPI_CMD_TIMEOUT_EN
  ,
  parameter int unsigned TIMEOUT_CYCLES = 1024
`endif
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic [WIDTH-1:0]                 in_data,
  input  logic                             in_vld,
  output logic                             in_rdy,
  output logic [WIDTH-1:0]                 cmd_op,
  output logic [$clog2(MAX_PAYLOAD+1)-1:0] cmd_len,
  output logic [MAX_PAYLOAD*WIDTH-1:0]     cmd_payload,
  output logic                             cmd_vld,
  input  logic                             cmd_rdy,
  output logic                             busy,
  output logic [7:0]                       err_count
);

  import spi_cmd_pkg::*;

  localparam int unsigned LW = $clog2(MAX_PAYLOAD + 1);
  localparam int unsigned PW = MAX_PAYLOAD * WIDTH;

  cmd_state_t       state, state_nxt;
  logic [WIDTH-1:0] op_nxt;
  logic [LW-1:0]    len_nxt;
  logic [PW-1:0]    payload_nxt;
  logic [LW-1:0]    remaining, remaining_nxt;
  logic             accept;
  logic             err_inc;
  op_info_t         info;

`ifdef SPI_CMD_TIMEOUT_EN
  localparam int unsigned IW = $clog2(TIMEOUT_CYCLES + 1);
  logic [IW-1:0] idle_cnt, idle_cnt_nxt;
`endif

  // in_rdy is a registered copy of "state is not EMIT", so it matches state.
  assign accept = in_vld && in_rdy;

  // Next-state and datapath update.
  always_comb begin
    state_nxt     = state;
    op_nxt        = cmd_op;
    len_nxt       = cmd_len;
    payload_nxt   = cmd_payload;
    remaining_nxt = remaining;
    err_inc       = 1'b0;
    info          = op_len(8'(in_data));
`ifdef SPI_CMD_TIMEOUT_EN
    idle_cnt_nxt  = '0;
`endif
    case (state)
      IDLE: begin
        if (accept) begin
          if (!info.valid) begin
            err_inc = 1'b1;
          end else begin
            op_nxt        = in_data;
            len_nxt       = LW'(info.len);
            remaining_nxt = LW'(info.len);
            payload_nxt   = '0;
            state_nxt     = (info.len == '0) ? EMIT : PAYLOAD;
          end
        end
      end
      PAYLOAD: begin
        if (accept) begin
          payload_nxt   = {cmd_payload[PW-WIDTH-1:0], in_data};
          remaining_nxt = remaining - LW'(1);
          if (remaining == LW'(1)) begin
            state_nxt = EMIT;
          end
        end
`ifdef SPI_CMD_TIMEOUT_EN
        // Stalled sender: drop the partial packet and count it.
        else if (idle_cnt == IW'(TIMEOUT_CYCLES - 1)) begin
          state_nxt = IDLE;
          err_inc   = 1'b1;
        end else begin
          idle_cnt_nxt = idle_cnt + IW'(1);
        end
`endif
      end
      EMIT: begin
        if (cmd_rdy) begin
          state_nxt = IDLE;
        end
      end
      default: state_nxt = IDLE;
    endcase
  end

  // State, command registers and handshake flags derived from next state.
  always_ff @(posedge clk) begin
    if (reset) begin
      state       <= IDLE;
      cmd_op      <= '0;
      cmd_len     <= '0;
      cmd_payload <= '0;
      remaining   <= '0;
      in_rdy      <= 1'b1;
      cmd_vld     <= 1'b0;
      busy        <= 1'b0;
    end else begin
      state       <= state_nxt;
      cmd_op      <= op_nxt;
      cmd_len     <= len_nxt;
      cmd_payload <= payload_nxt;
      remaining   <= remaining_nxt;
      in_rdy      <= (state_nxt != EMIT);
      cmd_vld     <= (state_nxt == EMIT);
      busy        <= (state_nxt == PAYLOAD);
    end
  end

`ifdef SPI_CMD_TIMEOUT_EN
  // Idle cycle counter, only advances in PAYLOAD without an accept.
  always_ff @(posedge clk) begin
    if (reset) begin
      idle_cnt <= '0;
    end else begin
      idle_cnt <= idle_cnt_nxt;
    end
  end
`endif

  spi_cmd_decoder_sat_counter #(.W(8)) u_err_cnt (
    .clk   (clk),
    .reset (reset),
    .inc   (err_inc),
    .count (err_count)
  );

endmodule

// File: tb/tb_spi_cmd_decoder.sv
// Directed self-checking bench for spi_cmd_decoder.
module tb_spi_cmd_decoder;

  logic        clk;
  logic        reset;
  logic [7:0]  in_data;
  logic        in_vld;
  logic        in_rdy;
  logic [7:0]  cmd_op;
  logic [2:0]  cmd_len;
  logic [31:0] cmd_payload;
  logic        cmd_vld;
  logic        cmd_rdy;
  logic        busy;
  logic [7:0]  err_count;

  int tests_run = 0;
  int tests_failed = 0;

  typedef struct packed {
    logic [7:0]  op;
    logic [2:0]  len;
    logic [31:0] pl;
  } cmd_t;

  cmd_t got[$];

`ifdef SPI_CMD_TIMEOUT_EN
  spi_cmd_decoder #(.TIMEOUT_CYCLES(16)) dut (
`else
  spi_cmd_decoder dut (
`endif
    .clk         (clk),
    .reset       (reset),
    .in_data     (in_data),
    .in_vld      (in_vld),
    .in_rdy      (in_rdy),
    .cmd_op      (cmd_op),
    .cmd_len     (cmd_len),
    .cmd_payload (cmd_payload),
    .cmd_vld     (cmd_vld),
    .cmd_rdy     (cmd_rdy),
    .busy        (busy),
    .err_count   (err_count)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Record every command handshake; inputs only change on negedge.
  always @(negedge clk) begin
    #1;
    if (cmd_vld && cmd_rdy) got.push_back({cmd_op, cmd_len, cmd_payload});
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  // Present one byte, wait (bounded) for acceptance, return on the next negedge.
  task automatic send_byte(input logic [7:0] b);
    int n;
    n = 0;
    in_data = b;
    in_vld  = 1'b1;
    while (!in_rdy && n < 100) begin
      @(negedge clk);
      n++;
    end
    if (!in_rdy) begin
      tests_run++;
      tests_failed++;
      $display("FAIL send_byte_timeout: byte %02h never accepted", b);
    end
    @(negedge clk);
    in_vld = 1'b0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    reset = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    tests_run++; if (in_rdy !== 1'b1) begin tests_failed++; $display("FAIL reset_in_rdy: got %b want 1", in_rdy); end
    tests_run++; if (cmd_vld !== 1'b0) begin tests_failed++; $display("FAIL reset_cmd_vld: got %b want 0", cmd_vld); end
    tests_run++; if (cmd_op !== 8'h00) begin tests_failed++; $display("FAIL reset_cmd_op: got %h want 00", cmd_op); end
    tests_run++; if (cmd_len !== 3'd0) begin tests_failed++; $display("FAIL reset_cmd_len: got %0d want 0", cmd_len); end
    tests_run++; if (cmd_payload !== 32'h0) begin tests_failed++; $display("FAIL reset_payload: got %h want 0", cmd_payload); end
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL reset_busy: got %b want 0", busy); end
    tests_run++; if (err_count !== 8'd0) begin tests_failed++; $display("FAIL reset_err: got %0d want 0", err_count); end
  endtask

  task automatic test_cfg_write();
    cmd_rdy = 1'b1;
    got.delete();
    send_byte(8'h04);
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL cfg_busy: got %b want 1", busy); end
    send_byte(8'hDE);
    send_byte(8'hAD);
    send_byte(8'hBE);
    tests_run++; if (cmd_vld !== 1'b0) begin tests_failed++; $display("FAIL cfg_early_vld: got %b want 0", cmd_vld); end
    send_byte(8'hEF);
    tests_run++; if (cmd_vld !== 1'b1) begin tests_failed++; $display("FAIL cfg_vld_latency: got %b want 1", cmd_vld); end
    tests_run++; if (in_rdy !== 1'b0) begin tests_failed++; $display("FAIL cfg_emit_in_rdy: got %b want 0", in_rdy); end
    @(negedge clk); #2;
    tests_run++; if (cmd_vld !== 1'b0) begin tests_failed++; $display("FAIL cfg_vld_drop: got %b want 0", cmd_vld); end
    tests_run++;
    if (got.size() != 1) begin
      tests_failed++; $display("FAIL cfg_count: got %0d commands want 1", got.size());
    end else if (got[0] !== {8'h04, 3'd4, 32'hDEADBEEF}) begin
      tests_failed++; $display("FAIL cfg_cmd: got op=%h len=%0d pl=%h want op=04 len=4 pl=deadbeef",
                               got[0].op, got[0].len, got[0].pl);
    end
  endtask

  task automatic test_backpressure();
    logic [42:0] snap;
    cmd_rdy = 1'b0;
    got.delete();
    send_byte(8'h01);
    send_byte(8'h12);
    send_byte(8'h34);
    snap = {cmd_op, cmd_len, cmd_payload};
    tests_run++; if (snap !== {8'h01, 3'd2, 32'h00001234}) begin tests_failed++; $display("FAIL bp_first_cmd: got %h want %h", snap, {8'h01, 3'd2, 32'h00001234}); end
    in_data = 8'h02;
    in_vld  = 1'b1;
    for (int i = 0; i < 5; i++) begin
      @(negedge clk);
      tests_run++;
      if (cmd_vld !== 1'b1 || in_rdy !== 1'b0 || {cmd_op, cmd_len, cmd_payload} !== snap) begin
        tests_failed++;
        $display("FAIL bp_hold_%0d: vld=%b in_rdy=%b cmd=%h want vld=1 in_rdy=0 cmd=%h",
                 i, cmd_vld, in_rdy, {cmd_op, cmd_len, cmd_payload}, snap);
      end
    end
    cmd_rdy = 1'b1;
    send_byte(8'h02);
    send_byte(8'h07);
    @(negedge clk); #2;
    tests_run++;
    if (got.size() != 2) begin
      tests_failed++; $display("FAIL bp_count: got %0d commands want 2", got.size());
    end else begin
      if (got[0] !== {8'h01, 3'd2, 32'h00001234}) begin
        tests_failed++; $display("FAIL bp_cmd0: got op=%h pl=%h want op=01 pl=00001234", got[0].op, got[0].pl);
      end
      tests_run++;
      if (got[1] !== {8'h02, 3'd1, 32'h00000007}) begin
        tests_failed++; $display("FAIL bp_cmd1: got op=%h len=%0d pl=%h want op=02 len=1 pl=00000007",
                                 got[1].op, got[1].len, got[1].pl);
      end
    end
  endtask

  task automatic test_invalid_op();
    cmd_rdy = 1'b1;
    got.delete();
    send_byte(8'h55);
    tests_run++; if (err_count !== 8'd1) begin tests_failed++; $display("FAIL inv_err: got %0d want 1", err_count); end
    tests_run++; if (busy !== 1'b0 || cmd_vld !== 1'b0) begin tests_failed++; $display("FAIL inv_state: busy=%b vld=%b want 0 0", busy, cmd_vld); end
    send_byte(8'h08);
    tests_run++; if (cmd_vld !== 1'b1) begin tests_failed++; $display("FAIL inv_clear_vld: got %b want 1", cmd_vld); end
    @(negedge clk); #2;
    tests_run++;
    if (got.size() != 1) begin
      tests_failed++; $display("FAIL inv_count: got %0d commands want 1", got.size());
    end else if (got[0] !== {8'h08, 3'd0, 32'h0}) begin
      tests_failed++; $display("FAIL inv_cmd: got op=%h len=%0d pl=%h want op=08 len=0 pl=0",
                               got[0].op, got[0].len, got[0].pl);
    end
  endtask

  task automatic test_saturation();
    cmd_rdy = 1'b1;
    got.delete();
    for (int i = 0; i < 10; i++) send_byte(8'hFF);
    tests_run++; if (err_count !== 8'd11) begin tests_failed++; $display("FAIL sat_partial: got %0d want 11", err_count); end
    for (int i = 10; i < 300; i++) send_byte(8'hFF);
    tests_run++; if (err_count !== 8'd255) begin tests_failed++; $display("FAIL sat_err: got %0d want 255", err_count); end
    tests_run++; if (got.size() != 0) begin tests_failed++; $display("FAIL sat_no_cmd: got %0d commands want 0", got.size()); end
  endtask

  task automatic test_reset_midpacket();
    cmd_rdy = 1'b1;
    got.delete();
    send_byte(8'h04);
    send_byte(8'hAA);
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL mid_busy: got %b want 1", busy); end
    reset = 1'b1;
    @(negedge clk);
    reset = 1'b0;
    tests_run++;
    if (in_rdy !== 1'b1 || cmd_vld !== 1'b0 || busy !== 1'b0 || err_count !== 8'd0 ||
        cmd_op !== 8'h00 || cmd_len !== 3'd0 || cmd_payload !== 32'h0) begin
      tests_failed++;
      $display("FAIL mid_reset_vals: in_rdy=%b vld=%b busy=%b err=%0d op=%h len=%0d pl=%h want 1 0 0 0 00 0 0",
               in_rdy, cmd_vld, busy, err_count, cmd_op, cmd_len, cmd_payload);
    end
    send_byte(8'h02);
    send_byte(8'h01);
    @(negedge clk); #2;
    tests_run++;
    if (got.size() != 1) begin
      tests_failed++; $display("FAIL mid_count: got %0d commands want 1", got.size());
    end else if (got[0] !== {8'h02, 3'd1, 32'h00000001}) begin
      tests_failed++; $display("FAIL mid_cmd: got op=%h pl=%h want op=02 pl=00000001", got[0].op, got[0].pl);
    end
    tests_run++; if (err_count !== 8'd0) begin tests_failed++; $display("FAIL mid_err: got %0d want 0", err_count); end
  endtask

`ifdef SPI_CMD_TIMEOUT_EN
  task automatic test_timeout();
    do_reset();
    cmd_rdy = 1'b1;
    got.delete();
    send_byte(8'h01);
    send_byte(8'h12);
    for (int i = 0; i < 15; i++) @(negedge clk);
    tests_run++; if (busy !== 1'b1) begin tests_failed++; $display("FAIL to_early: busy=%b want 1 after 15 idle", busy); end
    @(negedge clk);
    tests_run++; if (busy !== 1'b0) begin tests_failed++; $display("FAIL to_busy: got %b want 0", busy); end
    tests_run++; if (err_count !== 8'd1) begin tests_failed++; $display("FAIL to_err: got %0d want 1", err_count); end
    tests_run++; if (got.size() != 0) begin tests_failed++; $display("FAIL to_no_cmd: got %0d want 0", got.size()); end
    send_byte(8'h02);
    send_byte(8'h03);
    @(negedge clk); #2;
    tests_run++;
    if (got.size() != 1 || got[0] !== {8'h02, 3'd1, 32'h00000003}) begin
      tests_failed++; $display("FAIL to_after: got %0d commands, first=%h want 1 x 02/1/00000003",
                               got.size(), (got.size() > 0) ? got[0] : 43'h0);
    end
  endtask
`endif

  initial begin
    reset   = 1'b1;
    in_data = 8'h00;
    in_vld  = 1'b0;
    cmd_rdy = 1'b0;
    @(negedge clk);
    test_reset();
    test_cfg_write();
    test_backpressure();
    test_invalid_op();
    test_saturation();
    test_reset_midpacket();
`ifdef SPI_CMD_TIMEOUT_EN
    test_timeout();
`endif
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
